// File: rtl/fp_addsub_seq.sv
// Iterative IEEE-754 binary32 add/subtract unit with valid/ready handshakes.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only while idle)
//   sign*/exp*/sig*       unpacked operands; opcode 0 = add, 1 = subtract
//   out_valid / out_ready result handshake; result held until taken
//   fp_out, err_o         packed result and error code (0 none, 1 ovf, 2 unf, 3 invalid)
module fp_addsub_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign1,
    input  logic        sign2,
    input  logic [7:0]  exp1,
    input  logic [7:0]  exp2,
    input  logic [22:0] sig1,
    input  logic [22:0] sig2,
    input  logic        opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_out,
    output logic [2:0]  err_o
);
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MAN_W  = FRAC_W + 4;   // hidden + fraction + G/R/S
    localparam int unsigned EXPR_W = EXP_W + 2;    // headroom for carry/round increments

    localparam logic [2:0]  ERR_NONE     = 3'd0;
    localparam logic [2:0]  ERR_OVERFLOW = 3'd1;
    localparam logic [2:0]  ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0]  ERR_INVALID  = 3'd3;
    localparam logic [31:0] QNAN         = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [EXP_W-1:0]    a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [FRAC_W-1:0]   a_frac_q, a_frac_d, b_frac_q, b_frac_d;
    logic                res_sign_q, res_sign_d, sml_sign_q, sml_sign_d;
    logic [EXPR_W-1:0]   exp_q, exp_d;
    logic [EXP_W-1:0]    diff_q, diff_d;
    logic [MAN_W-1:0]    man_l_q, man_l_d, man_s_q, man_s_d;
    logic                in_ready_d, out_valid_d;
    logic [31:0]         fp_out_d;
    logic [2:0]          err_d;

    // Operand classification and ordering (used in SPECIAL)
    logic                a_nan, a_inf, b_nan, b_inf, a_ge_b;
    logic [EXP_W-1:0]    a_eexp, b_eexp, sep_diff;
    logic [MAN_W-1:0]    a_man, b_man;

    assign a_nan  = (a_exp_q == 8'hFF) && (a_frac_q != '0);
    assign a_inf  = (a_exp_q == 8'hFF) && (a_frac_q == '0);
    assign b_nan  = (b_exp_q == 8'hFF) && (b_frac_q != '0);
    assign b_inf  = (b_exp_q == 8'hFF) && (b_frac_q == '0);
    // Denormals use effective exponent 1 with a zero hidden bit
    assign a_eexp = (a_exp_q == '0) ? 8'd1 : a_exp_q;
    assign b_eexp = (b_exp_q == '0) ? 8'd1 : b_exp_q;
    assign a_man  = {a_exp_q != '0, a_frac_q, 3'b000};
    assign b_man  = {b_exp_q != '0, b_frac_q, 3'b000};
    assign a_ge_b = {a_eexp, a_man} >= {b_eexp, b_man};
    assign sep_diff = a_ge_b ? (a_eexp - b_eexp) : (b_eexp - a_eexp);

    // Magnitude add/subtract; larger minus smaller never goes negative
    logic              eff_sub;
    logic [MAN_W:0]    add_sum;
    assign eff_sub = res_sign_q ^ sml_sign_q;
    assign add_sum = eff_sub ? ({1'b0, man_l_q} - {1'b0, man_s_q})
                             : ({1'b0, man_l_q} + {1'b0, man_s_q});

    // Round to nearest even on G/R/S; rnd[24] is mantissa overflow, rnd[23] the hidden bit
    logic              round_up;
    logic [24:0]       rnd;
    logic [EXPR_W-1:0] rnd_exp;
    logic [FRAC_W-1:0] rnd_frac;
    assign round_up = man_l_q[2] & (man_l_q[1] | man_l_q[0] | man_l_q[3]);
    assign rnd      = {1'b0, man_l_q[MAN_W-1:3]} + 25'(round_up);
    assign rnd_exp  = rnd[24] ? (exp_q + 10'd1) : (rnd[23] ? exp_q : '0);
    assign rnd_frac = rnd[24] ? rnd[23:1] : rnd[22:0];

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        a_sign_d    = a_sign_q;
        b_sign_d    = b_sign_q;
        a_exp_d     = a_exp_q;
        b_exp_d     = b_exp_q;
        a_frac_d    = a_frac_q;
        b_frac_d    = b_frac_q;
        res_sign_d  = res_sign_q;
        sml_sign_d  = sml_sign_q;
        exp_d       = exp_q;
        diff_d      = diff_q;
        man_l_d     = man_l_q;
        man_s_d     = man_s_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        fp_out_d    = fp_out;
        err_d       = err_o;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sign_d   = sign1;
                    b_sign_d   = sign2 ^ opcode;
                    a_exp_d    = exp1;
                    b_exp_d    = exp2;
                    a_frac_d   = sig1;
                    b_frac_d   = sig2;
                    in_ready_d = 1'b0;
                    state_d    = S_SPECIAL;
                end
            end
            S_SPECIAL: begin
                if (a_nan || b_nan || (a_inf && b_inf && (a_sign_q != b_sign_q))) begin
                    fp_out_d    = QNAN;
                    err_d       = ERR_INVALID;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (a_inf || b_inf) begin
                    fp_out_d    = {a_inf ? a_sign_q : b_sign_q, 8'hFF, 23'd0};
                    err_d       = ERR_NONE;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    res_sign_d = a_ge_b ? a_sign_q : b_sign_q;
                    sml_sign_d = a_ge_b ? b_sign_q : a_sign_q;
                    exp_d      = EXPR_W'(a_ge_b ? a_eexp : b_eexp);
                    man_l_d    = a_ge_b ? a_man : b_man;
                    man_s_d    = a_ge_b ? b_man : a_man;
                    diff_d     = sep_diff;
                    state_d    = (sep_diff == '0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (diff_q >= 8'd27) begin
                    // Every bit falls below the round position: keep only sticky
                    man_s_d = {26'd0, |man_s_q};
                    diff_d  = '0;
                    state_d = S_ADD;
                end else begin
                    man_s_d = {1'b0, man_s_q[MAN_W-1:2], man_s_q[1] | man_s_q[0]};
                    diff_d  = diff_q - 8'd1;
                    if (diff_q == 8'd1) state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (add_sum == '0) begin
                    // Exact cancellation gives +0; only (-0)+(-0) keeps the minus sign
                    res_sign_d = eff_sub ? 1'b0 : res_sign_q;
                    man_l_d    = '0;
                    state_d    = S_ROUND;
                end else begin
                    if (add_sum[MAN_W]) begin
                        man_l_d = {add_sum[MAN_W:2], add_sum[1] | add_sum[0]};
                        exp_d   = exp_q + 10'd1;
                    end else begin
                        man_l_d = add_sum[MAN_W-1:0];
                    end
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (!man_l_q[MAN_W-1] && (exp_q > 10'd1)) begin
                    man_l_d = {man_l_q[MAN_W-2:0], 1'b0};
                    exp_d   = exp_q - 10'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_exp >= 10'd255) begin
                    fp_out_d = {res_sign_q, 8'hFF, 23'd0};
                    err_d    = ERR_OVERFLOW;
                end else begin
                    fp_out_d = {res_sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    err_d    = ((rnd_exp == '0) && (rnd_frac != '0)) ? ERR_UNDERFLOW : ERR_NONE;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            a_exp_q    <= '0;
            b_exp_q    <= '0;
            a_frac_q   <= '0;
            b_frac_q   <= '0;
            res_sign_q <= 1'b0;
            sml_sign_q <= 1'b0;
            exp_q      <= '0;
            diff_q     <= '0;
            man_l_q    <= '0;
            man_s_q    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            fp_out     <= '0;
            err_o      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            a_sign_q   <= a_sign_d;
            b_sign_q   <= b_sign_d;
            a_exp_q    <= a_exp_d;
            b_exp_q    <= b_exp_d;
            a_frac_q   <= a_frac_d;
            b_frac_q   <= b_frac_d;
            res_sign_q <= res_sign_d;
            sml_sign_q <= sml_sign_d;
            exp_q      <= exp_d;
            diff_q     <= diff_d;
            man_l_q    <= man_l_d;
            man_s_q    <= man_s_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            fp_out     <= fp_out_d;
            err_o      <= err_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: expected results are queued at issue and
// popped when out_valid appears. Latency is the cycle index of the first
// out_valid cycle, counting the cycle that starts at the accept edge as 1.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        sign1, sign2;
    logic [7:0]  exp1, exp2;
    logic [22:0] sig1, sig2;
    logic        opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_out;
    logic [2:0]  err_o;

    localparam logic [2:0] E_NONE = 3'd0, E_OVF = 3'd1, E_UNF = 3'd2, E_INV = 3'd3;

    typedef struct packed {
        logic [31:0] fp;
        logic [2:0]  err;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] fp;
        logic [2:0]  err;
        logic [7:0]  lat;   // 0 = latency not checked
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fp_addsub_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
        .sig1(sig1), .sig2(sig2), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_out(fp_out), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                                input logic [31:0] fp, input logic [2:0] err, input logic [7:0] lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.fp = fp; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Present one operand set for exactly one accept edge, then scramble the fields
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
        @(negedge clk);
        in_valid = 1'b1;
        sign1 = a[31]; exp1 = a[30:23]; sig1 = a[22:0];
        sign2 = b[31]; exp2 = b[30:23]; sig2 = b[22:0];
        opcode = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sign1 = 1'($urandom); exp1 = 8'($urandom); sig1 = 23'($urandom);
        sign2 = 1'($urandom); exp2 = 8'($urandom); sig2 = 23'($urandom);
        opcode = 1'($urandom);
    endtask

    // Called just after the accept edge; returns at the negedge where out_valid is seen
    task automatic wait_out(output int lat, output bit timed_out);
        lat = 1;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (fp_out !== 32'h0)    begin n_fail++; $display("FAIL reset_fp_out got %h want 00000000", fp_out); end
        n_checks++; if (err_o !== E_NONE)    begin n_fail++; $display("FAIL reset_err got %0d want 0", err_o); end
    endtask

    task automatic test_arith();
        vec_t v[$];
        exp_t e;
        int   lat;
        bit   to;
        v.push_back(mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, E_NONE, 8'd5));
        v.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, E_NONE, 8'd0));
        v.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, E_NONE, 8'd0));
        v.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, E_OVF,  8'd0));
        v.push_back(mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, E_UNF,  8'd0));
        v.push_back(mk(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, E_NONE, 8'd7));
        v.push_back(mk(32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, E_NONE, 8'd0));
        v.push_back(mk(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, E_NONE, 8'd0));
        v.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, E_NONE, 8'd0));
        v.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, E_NONE, 8'd0));
        foreach (v[i]) begin
            sb.push_back('{fp: v[i].fp, err: v[i].err});
            issue(v[i].a, v[i].b, v[i].op);
            wait_out(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL arith%0d_timeout no out_valid within 100 cycles", i);
            end else begin
                n_checks++;
                if (fp_out !== e.fp) begin n_fail++; $display("FAIL arith%0d_fp got %h want %h", i, fp_out, e.fp); end
                n_checks++;
                if (err_o !== e.err) begin n_fail++; $display("FAIL arith%0d_err got %0d want %0d", i, err_o, e.err); end
                if (v[i].lat != 8'd0) begin
                    n_checks++;
                    if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL arith%0d_latency got %0d want %0d", i, lat, v[i].lat); end
                end
                consume();
            end
        end
    endtask

    task automatic test_special();
        vec_t v[$];
        exp_t e;
        int   lat;
        bit   to;
        v.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, E_INV,  8'd2));
        v.push_back(mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, E_INV,  8'd2));
        v.push_back(mk(32'h3F800000, 32'h7F800001, 1'b1, 32'h7FC00000, E_INV,  8'd2));
        v.push_back(mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, E_NONE, 8'd2));
        v.push_back(mk(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, E_NONE, 8'd2));
        v.push_back(mk(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, E_NONE, 8'd2));
        foreach (v[i]) begin
            sb.push_back('{fp: v[i].fp, err: v[i].err});
            issue(v[i].a, v[i].b, v[i].op);
            wait_out(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL special%0d_timeout no out_valid within 100 cycles", i);
            end else begin
                n_checks++;
                if (fp_out !== e.fp) begin n_fail++; $display("FAIL special%0d_fp got %h want %h", i, fp_out, e.fp); end
                n_checks++;
                if (err_o !== e.err) begin n_fail++; $display("FAIL special%0d_err got %0d want %0d", i, err_o, e.err); end
                n_checks++;
                if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL special%0d_latency got %0d want %0d", i, lat, v[i].lat); end
                consume();
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        bit   to;
        int   extra;
        sb.push_back('{fp: 32'h3F800000, err: E_NONE});
        issue(32'h3F800000, 32'h30800000, 1'b0);
        wait_out(lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL bp_timeout no out_valid within 100 cycles");
        end else begin
            // Offer a new operand set while stalled; it must be ignored
            in_valid = 1'b1;
            sign1 = 1'b0; exp1 = 8'h40; sig1 = 23'h123;
            sign2 = 1'b1; exp2 = 8'h41; sig2 = 23'h456;
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (fp_out !== e.fp)   begin n_fail++; $display("FAIL bp_hold%0d_fp got %h want %h", i, fp_out, e.fp); end
                n_checks++; if (err_o !== e.err)   begin n_fail++; $display("FAIL bp_hold%0d_err got %0d want %0d", i, err_o, e.err); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d_valid got %b want 1", i, out_valid); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d_in_ready got %b want 0", i, in_ready); end
                @(negedge clk);
            end
            in_valid = 1'b0;
            consume();
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got %b want 0", out_valid); end
            n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_after_in_ready got %b want 1", in_ready); end
            extra = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            n_checks++; if (extra != 0) begin n_fail++; $display("FAIL bp_single_handshake got %0d extra valid cycles want 0", extra); end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        bit   to;
        int   stray;
        // 1.0 + 2^-20: exponent difference 20, aborted mid-alignment
        issue(32'h3F800000, 32'h35800000, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        n_checks++; if (fp_out !== 32'h0)   begin n_fail++; $display("FAIL abort_fp_out got %h want 00000000", fp_out); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_no_valid got %0d valid cycles want 0", stray); end
        sb.push_back('{fp: 32'h40400000, err: E_NONE});
        issue(32'h3FC00000, 32'h3FC00000, 1'b0);
        wait_out(lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL abort_next_timeout no out_valid within 100 cycles");
        end else begin
            n_checks++; if (fp_out !== e.fp) begin n_fail++; $display("FAIL abort_next_fp got %h want %h", fp_out, e.fp); end
            n_checks++; if (err_o !== e.err) begin n_fail++; $display("FAIL abort_next_err got %0d want %0d", err_o, e.err); end
            consume();
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size()); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign1 = 1'b0; sign2 = 1'b0; exp1 = '0; exp2 = '0; sig1 = '0; sig2 = '0; opcode = 1'b0;
        test_reset();
        test_arith();
        test_special();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end
endmodule
